vga_console_feeder: RTL and testbench

AHB-Lite slave that buffers characters written by the Cortex-M3 and streams them into the VGA text console as single-cycle `font_we`/`font_data` strobes. It sits directly upstream of the console. It holds off delivery while the console clears video RAM after reset or scrolls, and while the console may be about to start a scroll. A bounded FIFO decouples software from these stalls. Software sees back-pressure only as AHB wait states when the FIFO is full.

---
 rtl/vga_console_feeder.sv | 202 ++++++++++++++++++++
 tb/tb_vga_console_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_console_feeder.sv
// -----------------------------------------------------------------------------
// vga_console_feeder
//
// AHB-Lite slave that buffers characters from the CPU and delivers them to the
// VGA text console as one-cycle font_we/font_data strobes.
//
// Delivery is held off in three situations:
//   - for INIT_HOLD cycles after reset, while the console clears video RAM;
//   - while the console reports a scroll in progress;
//   - for one cycle after every strobe, because a strobe can trigger a scroll.
//
// A FIFO of 2^FIFO_AW characters absorbs these stalls. A DATA write into a
// full FIFO is held with wait states until a slot frees up.
//
// Ports
//   clk, resetn              clock and asynchronous active-low reset
//   hsel, haddr, htrans,
//   hwrite, hsize, hready,
//   hwdata                   AHB-Lite slave inputs (only haddr[3:2] decoded)
//   hreadyout, hrdata, hresp AHB-Lite slave outputs (hresp always OKAY)
//   scroll                   console scroll-busy flag
//   font_we, font_data       character strobe and character to the console
//
// Register map (haddr[3:2])
//   0 DATA    write pushes hwdata[7:0]; reads 0
//   1 STATUS  bit0 full, bit1 empty, bit2 scroll, bit3 init_busy,
//             bits[15:8] fill level
//   2 CTRL    write with hwdata[0]=1 flushes the FIFO; reads 0
//   3         reserved
// -----------------------------------------------------------------------------
module vga_console_feeder #(
    parameter int FIFO_AW   = 4,
    parameter int INIT_HOLD = 4096
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        hsel,
    input  logic [11:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp,
    input  logic        scroll,
    output logic        font_we,
    output logic [7:0]  font_data
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int HOLD_W = (INIT_HOLD > 1) ? $clog2(INIT_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'((INIT_HOLD > 0) ? INIT_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   DEPTH_P   = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [FIFO_AW:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]    rd_ptr_q, rd_ptr_d;
    logic                dp_valid_q, dp_valid_d;
    logic                dp_write_q, dp_write_d;
    logic [1:0]          dp_addr_q, dp_addr_d;
    logic                font_we_q, font_we_d;
    logic [7:0]          font_data_q, font_data_d;
    logic [7:0]          mem_q [DEPTH];

    logic [FIFO_AW:0]    level;
    logic                full;
    logic                empty;
    logic                init_busy;
    logic                dp_data_wr;
    logic                push;
    logic                pop;
    logic                flush;
    logic [31:0]         status;

    // Bus inputs that carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = &{1'b0, hsize, haddr[11:4], haddr[1:0], htrans[0], hwdata[31:8]};

    // ---------------------------------------------------------------- FIFO flags
    assign level     = wr_ptr_q - rd_ptr_q;
    assign full      = (level == DEPTH_P);
    assign empty     = (level == '0);
    assign init_busy = (state_q == ST_INIT);

    // ---------------------------------------------------------------- data phase
    assign dp_data_wr = dp_valid_q & dp_write_q & (dp_addr_q == 2'd0);
    // A DATA write into a full FIFO is the only transfer that waits. Because this
    // is combinational on the level, it rises in the cycle after a freeing pop.
    assign hreadyout  = ~(dp_data_wr & full);
    assign push       = dp_data_wr & ~full;
    assign flush      = dp_valid_q & dp_write_q & (dp_addr_q == 2'd2) & hwdata[0];
    assign hresp      = 1'b0;

    assign status = {16'h0000, 8'(level), 4'h0, init_busy, scroll, empty, full};
    assign hrdata = (dp_valid_q & ~dp_write_q & (dp_addr_q == 2'd1)) ? status : 32'h0;

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        // A new address phase is accepted only when the previous transfer ends;
        // during our own wait states the stalled write stays in the data phase.
        if (hready) begin
            dp_valid_d = hsel & htrans[1];
            dp_write_d = hwrite;
            dp_addr_d  = haddr[3:2];
        end
    end

    // ---------------------------------------------------------------- delivery FSM
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        pop         = 1'b0;
        font_we_d   = 1'b0;
        font_data_d = font_data_q;
        case (state_q)
            ST_INIT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            ST_IDLE: begin
                // A flush in the same cycle cancels the pop and its strobe.
                if (!empty && !scroll && !flush) begin
                    pop         = 1'b1;
                    font_we_d   = 1'b1;
                    font_data_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                // The console raises scroll one cycle after the strobe that
                // triggers it, so IDLE must see scroll again before popping.
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // ---------------------------------------------------------------- pointers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_INIT;
            hold_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_addr_q   <= 2'd0;
            font_we_q   <= 1'b0;
            font_data_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_addr_q   <= dp_addr_d;
            font_we_q   <= font_we_d;
            font_data_q <= font_data_d;
        end
    end

    // Character storage has no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= hwdata[7:0];
        end
    end

    assign font_we   = font_we_q;
    assign font_data = font_data_q;

endmodule

// File: tb/tb_vga_console_feeder.sv
// -----------------------------------------------------------------------------
// tb_vga_console_feeder
//
// Directed bench for vga_console_feeder with INIT_HOLD=16 and a 16-entry FIFO.
// The bus ready is looped back from hreadyout, as in a single-slave system.
// A monitor logs every font_we strobe with the clock-edge number (edges counted
// from reset release) at which it was registered.
// -----------------------------------------------------------------------------
module tb_vga_console_feeder;

    localparam int HOLD      = 16;
    localparam int STALL_MAX = 5000;

    logic        clk;
    logic        resetn;
    logic        hsel;
    logic [11:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic        hresp;
    logic        scroll;
    logic        font_we;
    logic [7:0]  font_data;

    int checks = 0;
    int errors = 0;
    int edge_cnt;

    logic [7:0] strobe_data [$];
    int         strobe_edge [$];

    vga_console_feeder #(
        .FIFO_AW   (4),
        .INIT_HOLD (HOLD)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hready    (hready),
        .hwdata    (hwdata),
        .hreadyout (hreadyout),
        .hrdata    (hrdata),
        .hresp     (hresp),
        .scroll    (scroll),
        .font_we   (font_we),
        .font_data (font_data)
    );

    assign hready = hreadyout;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) edge_cnt <= 0;
        else         edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (font_we === 1'b1) begin
            strobe_data.push_back(font_data);
            strobe_edge.push_back(edge_cnt);
            $display("strobe data=%02h edge=%0d", font_data, edge_cnt);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge, with the bus ready.
    task automatic ahb_write(input logic [11:0] addr, input logic [31:0] data, output int waits);
        waits  = 0;
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = addr;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 12'h000;
        hwdata = data;
        @(negedge clk);
        while (hreadyout !== 1'b1 && waits < STALL_MAX) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= STALL_MAX) chk("write_stall_timeout", {31'h0, hreadyout}, 32'h1);
        @(posedge clk); #1;
        $display("write addr=%03h data=%08h waits=%0d", addr, data, waits);
    endtask

    task automatic ahb_read(input logic [11:0] addr, output logic [31:0] data);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b0;
        haddr  = addr;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 12'h000;
        hwdata = 32'h0;
        @(negedge clk);
        data = hrdata;
        chk("hresp_okay", {31'h0, hresp}, 32'h0);
        @(posedge clk); #1;
        $display("read  addr=%03h data=%08h", addr, data);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget && strobe_data.size() < n; i++) @(posedge clk);
        #1;
        chk("strobe_count", strobe_data.size(), n);
    endtask

    initial begin
        int          w;
        int          wv [20];
        int          bad;
        int          e_lf;
        int          fall_edge;
        logic [31:0] rd;

        resetn = 1'b1;
        hsel   = 1'b0;
        haddr  = 12'h000;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b000;
        hwdata = 32'h0;
        scroll = 1'b0;
        #1 resetn = 1'b0;

        // ---- reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hreadyout", {31'h0, hreadyout}, 32'h1);
        chk("rst_hrdata",    hrdata,               32'h0);
        chk("rst_hresp",     {31'h0, hresp},       32'h0);
        chk("rst_font_we",   {31'h0, font_we},     32'h0);
        chk("rst_font_data", {24'h0, font_data},   32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // ---- init hold: 'A' pushed at edge 2, strobe only after INIT ends
        ahb_write(12'h000, 32'h41, w);
        ahb_read(12'h004, rd);
        chk("init_status_busy", rd, 32'h0000_0108);
        wait_strobes(1, 40);
        repeat (4) @(posedge clk); #1;
        chk("init_strobe_count", strobe_data.size(), 1);
        chk("init_strobe_data",  {24'h0, strobe_data[0]}, 32'h41);
        chk("init_strobe_edge",  strobe_edge[0], HOLD + 1);
        ahb_read(12'h004, rd);
        chk("init_status_done", rd, 32'h0000_0002);

        // ---- burst of 20 with scroll held: 16 fit, the 17th stalls
        strobe_data.delete();
        strobe_edge.delete();
        scroll = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) ahb_write(12'h000, 32'h30 + i, wv[i]);
            end
            begin
                repeat (80) @(posedge clk); #1;
                scroll = 1'b0;
            end
        join
        bad = 0;
        for (int i = 0; i < 16; i++) if (wv[i] != 0) bad++;
        chk("burst_zero_wait", bad, 0);
        chk("burst_17_stalled", {31'h0, (wv[16] > 0)}, 32'h1);
        wait_strobes(20, 200);
        bad = 0;
        for (int i = 0; i < 20 && i < strobe_data.size(); i++)
            if (strobe_data[i] != 8'(8'h30 + i)) bad++;
        chk("burst_order", bad, 0);
        bad = 0;
        for (int i = 1; i < 20 && i < strobe_edge.size(); i++)
            if (strobe_edge[i] - strobe_edge[i-1] != 2) bad++;
        chk("burst_spacing", bad, 0);
        repeat (4) @(posedge clk); #1;

        // ---- LF triggers a scroll: 'B' must wait for scroll to fall
        strobe_data.delete();
        strobe_edge.delete();
        ahb_write(12'h000, 32'h0A, w);
        e_lf = edge_cnt;
        ahb_write(12'h000, 32'h42, w);
        scroll = 1'b1;
        repeat (100) @(posedge clk); #1;
        scroll = 1'b0;
        fall_edge = edge_cnt;
        wait_strobes(2, 20);
        chk("lf_data",     {24'h0, strobe_data[0]}, 32'h0A);
        chk("lf_latency",  strobe_edge[0], e_lf + 1);
        chk("b_data",      {24'h0, strobe_data[1]}, 32'h42);
        chk("b_after_scroll", strobe_edge[1], fall_edge + 1);

        // ---- status with 5 queued, then flush
        strobe_data.delete();
        strobe_edge.delete();
        scroll = 1'b1;
        for (int i = 0; i < 5; i++) ahb_write(12'h000, 32'h61 + i, w);
        ahb_read(12'h004, rd);
        chk("status_level5", rd, 32'h0000_0504);
        ahb_write(12'h008, 32'h1, w);
        ahb_read(12'h004, rd);
        chk("status_flushed", rd, 32'h0000_0006);
        scroll = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("flush_no_strobe", strobe_data.size(), 0);

        // ---- reset while full with a stalled write
        scroll = 1'b1;
        for (int i = 0; i < 16; i++) ahb_write(12'h000, 32'h70 + i, w);
        ahb_read(12'h004, rd);
        chk("status_full", rd, 32'h0000_1005);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = 12'h000;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = 32'h99;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_hreadyout", {31'h0, hreadyout}, 32'h0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_hreadyout", {31'h0, hreadyout}, 32'h1);
        chk("arst_font_we",   {31'h0, font_we},   32'h0);
        chk("arst_font_data", {24'h0, font_data}, 32'h0);
        chk("arst_hrdata",    hrdata,             32'h0);
        hwdata = 32'h0;
        scroll = 1'b0;
        repeat (2) @(posedge clk); #1;
        resetn = 1'b1;
        strobe_data.delete();
        strobe_edge.delete();
        ahb_read(12'h004, rd);
        chk("post_rst_status", rd, 32'h0000_000A);
        ahb_write(12'h000, 32'h5A, w);
        wait_strobes(1, 40);
        chk("post_rst_edge", strobe_edge[0], HOLD + 1);
        chk("post_rst_data", {24'h0, strobe_data[0]}, 32'h5A);

        // ---- non-status offsets read zero; reserved writes ignored
        repeat (2) @(posedge clk); #1;
        ahb_read(12'h000, rd);
        chk("read_data_zero", rd, 32'h0);
        ahb_read(12'h008, rd);
        chk("read_ctrl_zero", rd, 32'h0);
        ahb_read(12'h00C, rd);
        chk("read_rsvd_zero", rd, 32'h0);
        ahb_write(12'h00C, 32'h55, w);
        ahb_read(12'h004, rd);
        chk("rsvd_write_ignored", rd, 32'h0000_0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
